// File: rtl/life_grid_engine.sv
// life_grid_engine
// ----------------------------------------------------------------------------
// Parametrised Conway's Game of Life engine (rule B3/S23) on a ROWS x COLS
// grid. It replaces the older fixed 8x8 block. Cell (r,c) lives at bit
// r*COLS+c of seed and grid. The engine advances one generation per update
// event. Update events come from a single step pulse while idle, or from a
// free-running tick divider while run is held high.
//
// Optional feature (macro LIFE_PERIOD2_DETECT_EN):
//   Adds a prev_grid register and the osc2 output, which flags period-2
//   oscillation. With HALT_ON_STABLE=1, osc2 also halts the engine.
//
// Parameters:
//   ROWS, COLS      grid dimensions (>=3 each)
//   GEN_W           generation counter width
//   TICK_DIV        clocks per generation while running (>=1)
//   HALT_ON_STABLE  1 = enter HALT when an update is stable/extinct(/osc2)
//
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   load       1-cycle pulse, loads seed and returns to IDLE from any state
//   seed       initial pattern, ROWS*COLS bits
//   run        level, free-run at the TICK_DIV rate
//   step       pulse, one generation while IDLE and run=0
//   wrap_mode  1 = toroidal neighbours, 0 = cells outside the grid are dead
//   grid       current generation
//   gen_count  generations since the last load, saturating
//   stable     the last update produced next == grid
//   extinct    grid == 0
//   halted     engine is in HALT
//   osc2       (macro only) the last update returned to the grid of two
//              generations ago
// ----------------------------------------------------------------------------

// One cell: apply B3/S23 to a 3x3 window whose centre (bit 4) is the cell.
module life_cell (
  input  logic [8:0] win,
  output logic       next
);
  logic [3:0] cnt;

  always_comb begin
    cnt = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (k != 4) cnt = cnt + {3'b000, win[k]};
    end
    next = win[4] ? (cnt == 4'd2 || cnt == 4'd3) : (cnt == 4'd3);
  end
endmodule

module life_grid_engine #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int GEN_W          = 16,
  parameter int TICK_DIV       = 1,
  parameter int HALT_ON_STABLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 run,
  input  logic                 step,
  input  logic                 wrap_mode,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 stable,
  output logic                 extinct,
`ifdef LIFE_PERIOD2_DETECT_EN
  output logic                 osc2,
`endif
  output logic                 halted
);
  localparam int N  = ROWS * COLS;
  // The tick counter needs at least one bit even when TICK_DIV=1.
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t         state;
  logic [TW-1:0]  tick;
  logic [N-1:0]   next_grid;
  logic           tick_hit;
  logic           upd;
  logic           nxt_stable;
  logic           nxt_extinct;
  logic           halt_trig;

`ifdef LIFE_PERIOD2_DETECT_EN
  logic [N-1:0]   prev_grid;
  logic           nxt_osc2;
`endif

  // --------------------------------------------------------------------------
  // Next-generation array. Each cell builds its 3x3 window from the current
  // grid. Neighbour positions are known at elaboration time. A neighbour
  // inside the grid is wired straight through. A neighbour outside the grid
  // takes the wrapped cell, gated by wrap_mode, so wrap_mode=0 reads as dead.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [8:0] win;

      for (genvar i = 0; i < 3; i++) begin : g_dr
        for (genvar j = 0; j < 3; j++) begin : g_dc
          localparam int RI     = r + i - 1;
          localparam int CJ     = c + j - 1;
          localparam bit INSIDE = (RI >= 0) && (RI < ROWS) &&
                                  (CJ >= 0) && (CJ < COLS);
          localparam int RW     = (RI + ROWS) % ROWS;
          localparam int CW     = (CJ + COLS) % COLS;
          localparam int IDX    = RW * COLS + CW;

          if (INSIDE) begin : g_in
            assign win[i*3+j] = grid[IDX];
          end else begin : g_edge
            assign win[i*3+j] = wrap_mode & grid[IDX];
          end
        end
      end

      life_cell u_cell (
        .win  (win),
        .next (next_grid[r*COLS+c])
      );
    end
  end

  // --------------------------------------------------------------------------
  // Update event and halt decision
  // --------------------------------------------------------------------------
  assign tick_hit    = (tick == TW'(TICK_DIV - 1));
  // step is honoured only in IDLE with run low. In RUN, updates come from
  // the divider alone.
  assign upd         = ((state == IDLE) && !run && step) ||
                       ((state == RUN)  &&  run && tick_hit);
  assign nxt_stable  = (next_grid == grid);
  assign nxt_extinct = (next_grid == '0);

`ifdef LIFE_PERIOD2_DETECT_EN
  // A period-1 pattern also equals prev_grid, so it is excluded here. That
  // keeps osc2 reserved for true period-2 behaviour.
  assign nxt_osc2  = (next_grid == prev_grid) && !nxt_stable;
  assign halt_trig = (HALT_ON_STABLE != 0) &&
                     (nxt_stable || nxt_extinct || nxt_osc2);
`else
  assign halt_trig = (HALT_ON_STABLE != 0) && (nxt_stable || nxt_extinct);
`endif

  // --------------------------------------------------------------------------
  // State, counters and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tick      <= '0;
      grid      <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
      extinct   <= 1'b1;
      halted    <= 1'b0;
`ifdef LIFE_PERIOD2_DETECT_EN
      prev_grid <= '0;
      osc2      <= 1'b0;
`endif
    end else if (load) begin
      state     <= IDLE;
      tick      <= '0;
      grid      <= seed;
      gen_count <= '0;
      stable    <= 1'b0;
      extinct   <= (seed == '0);
      halted    <= 1'b0;
`ifdef LIFE_PERIOD2_DETECT_EN
      prev_grid <= '0;
      osc2      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state <= RUN;
            tick  <= '0;
          end
        end
        RUN: begin
          if (!run) begin
            state <= IDLE;
            tick  <= '0;
          end else if (tick_hit) begin
            tick <= '0;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        HALT: ;
        default: state <= IDLE;
      endcase

      if (upd) begin
        grid    <= next_grid;
        stable  <= nxt_stable;
        extinct <= nxt_extinct;
        if (gen_count != {GEN_W{1'b1}})
          gen_count <= gen_count + GEN_W'(1);
`ifdef LIFE_PERIOD2_DETECT_EN
        osc2      <= nxt_osc2;
        prev_grid <= grid;
`endif
        // The halt check covers every update, stepped or free-running. A
        // stepped pattern that dies out or freezes therefore parks in HALT
        // as well. This assignment comes after the case above, so it
        // overrides any transition made there.
        if (halt_trig) begin
          state  <= HALT;
          halted <= 1'b1;
        end
      end
    end
  end

endmodule
